// File: rtl/fft_pkg.sv
// Shared FFT spectrum-path definitions: frame geometry, magnitude width,
// writer state encoding and the bin address type.
package fft_pkg;

   localparam int FFT_N_LOG2 = 10;
   localparam int FFT_MAG_W  = 12;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef logic [FFT_N_LOG2-1:0] fft_bin_t;

endpackage

// File: rtl/fft_mag_approx.sv
// Three-stage alpha-max-beta-min magnitude: abs, max/min, then
// mag = max + (min>>2) + (min>>3) carried at IN_W+2 bits.
module fft_mag_approx
   import fft_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   input  logic signed [IN_W-1:0] re,
   input  logic signed [IN_W-1:0] im,
   output logic [IN_W+1:0]        mag,
   output logic                   mag_vld,
   output logic                   busy
);

   logic [IN_W:0]   abs_re_p0, abs_im_p0;
   logic [IN_W:0]   max_p1, min_p1;
   logic [IN_W+1:0] mag_p2;
   logic            vld_p0, vld_p1, vld_p2;

   // One extra bit so that the most negative input has a representable magnitude.
   function automatic logic [IN_W:0] abs_u(input logic signed [IN_W-1:0] x);
      logic signed [IN_W:0] xe;
      xe = {x[IN_W-1], x};
      if (xe[IN_W])
         return $unsigned(-xe);
      else
         return $unsigned(xe);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= in_vld;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      // p0: absolute values
      abs_re_p0 <= abs_u(re);
      abs_im_p0 <= abs_u(im);
      // p1: ordering
      max_p1    <= (abs_re_p0 > abs_im_p0) ? abs_re_p0 : abs_im_p0;
      min_p1    <= (abs_re_p0 > abs_im_p0) ? abs_im_p0 : abs_re_p0;
      // p2: weighted sum
      mag_p2    <= {1'b0, max_p1} + {3'b000, min_p1[IN_W:2]} + {4'b0000, min_p1[IN_W:3]};
   end

   assign mag     = mag_p2;
   assign mag_vld = vld_p2;
   assign busy    = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: rtl/fft_mag_writer.sv
// Converts FFT bins to saturated magnitudes and writes them by bin index.
// Optional FFT_MAG_DC_BLANK_EN forces bins 0 and 1 to zero.
module fft_mag_writer
   import fft_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int OUT_W  = FFT_MAG_W,
   parameter int N_LOG2 = FFT_N_LOG2,
   parameter int SHIFT  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic signed [IN_W-1:0] s_re,
   input  logic signed [IN_W-1:0] s_im,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [OUT_W-1:0]       data,
   output logic [N_LOG2-1:0]      addr,
   output logic                   valid,
   output logic                   frame_done,
   output logic                   frame_err
);

   localparam logic [N_LOG2-1:0] LAST_BIN = '1;
   localparam logic [N_LOG2-1:0] CNT_ONE  = {{(N_LOG2-1){1'b0}}, 1'b1};
   localparam logic [IN_W+1:0]   SAT_MAX  = (IN_W+2)'((1 << OUT_W) - 1);

   state_t            state, state_nxt;
   logic [N_LOG2-1:0] cnt, cnt_nxt;
   logic              xfer, at_last_bin, frame_end, bin_err;
   logic [IN_W+1:0]   mag;
   logic              mag_vld, busy, blank;
   logic [N_LOG2-1:0] addr_p0, addr_p1, addr_p2;
   logic              err_p0, err_p1, err_p2;

   function automatic logic [OUT_W-1:0] sat_shift(input logic [IN_W+1:0] m);
      logic [IN_W+1:0] sh;
      sh = m >> SHIFT;
      if (sh > SAT_MAX)
         return '1;
      else
         return sh[OUT_W-1:0];
   endfunction

   assign xfer        = s_valid && s_ready;
   assign at_last_bin = (cnt == LAST_BIN);
   assign frame_end   = xfer && (s_last || at_last_bin);
   // Early last and missing last are both a disagreement between s_last and the count.
   assign bin_err     = s_last != at_last_bin;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (enable) state_nxt = RUN;
         end
         RUN: begin
            if (xfer) begin
               cnt_nxt = frame_end ? '0 : cnt + CNT_ONE;
               if (frame_end && !enable) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         s_ready <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         s_ready <= (state_nxt == RUN);
      end
   end

   fft_mag_approx #(
      .IN_W (IN_W)
   ) u_mag (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (xfer),
      .re      (s_re),
      .im      (s_im),
      .mag     (mag),
      .mag_vld (mag_vld),
      .busy    (busy)
   );

   // p0..p2: bin address and error flag follow the magnitude pipeline
   always_ff @(posedge clk) begin
      addr_p0 <= cnt;
      err_p0  <= bin_err;
      addr_p1 <= addr_p0;
      err_p1  <= err_p0;
      addr_p2 <= addr_p1;
      err_p2  <= err_p1;
   end

`ifdef FFT_MAG_DC_BLANK_EN
   assign blank = (addr_p2[N_LOG2-1:1] == '0);
`else
   assign blank = 1'b0;
`endif

   // p3: saturation and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid      <= 1'b0;
         data       <= '0;
         addr       <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid      <= mag_vld;
         frame_done <= mag_vld && (addr_p2 == LAST_BIN);
         frame_err  <= mag_vld && err_p2;
         if (mag_vld) begin
            data <= blank ? '0 : sat_shift(mag);
            addr <= addr_p2;
         end
      end
   end

endmodule

// File: tb/tb_fft_mag_writer.sv
// Scoreboard bench for fft_mag_writer: randomized bins against a plain-arithmetic
// magnitude and frame-index model; monitor compares every write.
`timescale 1ns/1ps
module tb_fft_mag_writer;

   localparam int IN_W   = 16;
   localparam int OUT_W  = 12;
   localparam int N_LOG2 = 10;
   localparam int SHIFT  = 3;
   localparam int NBINS  = 1 << N_LOG2;
   localparam int TCLK   = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b0;
   logic s_valid = 1'b0;
   logic s_last = 1'b0;
   logic signed [IN_W-1:0] s_re = '0;
   logic signed [IN_W-1:0] s_im = '0;
   logic s_ready, valid, frame_done, frame_err;
   logic [OUT_W-1:0]  data;
   logic [N_LOG2-1:0] addr;

   typedef struct {
      int     data;
      int     addr;
      bit     done;
      bit     err;
      longint t;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   bin_idx = 0;
   int   dre[6] = '{3000, 3000, 3000, 32767, -32768, -8};
   int   dim[6] = '{4000, 4000, 4000, 32767, 0, 0};

   always #(TCLK/2) clk = ~clk;

   fft_mag_writer #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .N_LOG2 (N_LOG2),
      .SHIFT  (SHIFT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .s_re       (s_re),
      .s_im       (s_im),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .data       (data),
      .addr       (addr),
      .valid      (valid),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Magnitude straight from the alpha-max-beta-min formula on integers.
   function automatic int model_data(input int re, input int im, input int bin);
      int ar, ai, mx, mn, m;
      ar = (re < 0) ? -re : re;
      ai = (im < 0) ? -im : im;
      mx = (ar > ai) ? ar : ai;
      mn = (ar > ai) ? ai : ar;
      m  = (mx + mn / 4 + mn / 8) / (1 << SHIFT);
      if (m > (1 << OUT_W) - 1) m = (1 << OUT_W) - 1;
`ifdef FFT_MAG_DC_BLANK_EN
      if (bin < 2) m = 0;
`endif
      return m;
   endfunction

   function automatic int rnd_sample();
      case ($urandom_range(0, 7))
         0:       return 32767;
         1:       return -32768;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   function automatic int rnd_gap();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
   endfunction

   // Called just after a rising edge; returns just after the edge that took the bin.
   task automatic send(input int re, input int im, input bit last, input int gap);
      exp_t e;
      int   w;
      if (gap > 0) begin
         s_valid = 1'b0;
         s_last  = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      s_re    = IN_W'(re);
      s_im    = IN_W'(im);
      s_last  = last;
      s_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: s_ready stayed 0 for bin %0d, required 1", bin_idx);
      end else begin
         e.data = model_data(re, im, bin_idx);
         e.addr = bin_idx;
         e.done = (bin_idx == NBINS - 1);
         e.err  = (last != (bin_idx == NBINS - 1));
         e.t    = longint'($time);
         sb.push_back(e);
         bin_idx = (last || bin_idx == NBINS - 1) ? 0 : bin_idx + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0d, required no write", addr, data);
         end else begin
            mon_e = sb.pop_front();
            chk("latency", longint'($time), mon_e.t + 4 * TCLK);
            chk("data", data, mon_e.data);
            chk("addr", addr, mon_e.addr);
            chk("frame_done", frame_done, mon_e.done);
            chk("frame_err", frame_err, mon_e.err);
         end
      end else begin
         chk("done_idle", frame_done, 0);
         chk("err_idle", frame_err, 0);
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_addr", addr, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_err", frame_err, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_s_ready", s_ready, 0);
      enable = 1'b1;
      @(posedge clk);
      #1;
      chk("run_s_ready", s_ready, 1);

      // Full frame: directed bins first, then random with gaps, s_last on 1023.
      for (int i = 0; i < NBINS; i++) begin
         if (i < 6) send(dre[i], dim[i], 1'b0, 0);
         else       send(rnd_sample(), rnd_sample(), i == NBINS - 1, rnd_gap());
      end
      // Early last on bin 500.
      for (int i = 0; i <= 500; i++)
         send(rnd_sample(), rnd_sample(), i == 500, rnd_gap());
      // Missing last: 1024 bins with no marker.
      for (int i = 0; i < NBINS; i++)
         send(rnd_sample(), rnd_sample(), 1'b0, rnd_gap());
      // Enable dropped at bin 200; the frame must still complete.
      for (int i = 0; i < NBINS; i++) begin
         if (i == 200) enable = 1'b0;
         send(rnd_sample(), rnd_sample(), i == NBINS - 1, rnd_gap());
      end
      s_valid = 1'b1;
      s_re    = IN_W'(1234);
      s_im    = IN_W'(-999);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("drain_s_ready", s_ready, 0);
      end
      idle();
      wait_drain();

      // New frame, reset asserted while bin 300 is offered.
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rerun_s_ready", s_ready, 1);
      for (int i = 0; i < 300; i++)
         send(rnd_sample(), rnd_sample(), 1'b0, rnd_gap());
      s_re    = IN_W'(500);
      s_im    = IN_W'(700);
      s_valid = 1'b1;
      rst     = 1'b0;
      sb.delete();
      bin_idx = 0;
      #1;
      chk("rst_mid_valid", valid, 0);
      chk("rst_mid_s_ready", s_ready, 0);
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post_rst_s_ready", s_ready, 0);
         chk("post_rst_valid", valid, 0);
      end
      idle();
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
